// File: rtl/cga_intr_pkg.sv
// Shared definitions for the CGA interrupt priority controller.
//   - LAA register select codes
//   - controller FSM state type
//   - prio_enc: index of the highest set bit of a request vector (0 if none)
package cga_intr_pkg;

    localparam logic [1:0] LAA_PIE     = 2'd0;
    localparam logic [1:0] LAA_PID_SET = 2'd1;
    localparam logic [1:0] LAA_PID_CLR = 2'd2;
    localparam logic [1:0] LAA_PIL     = 2'd3;

    // Widest level vector prio_enc accepts; narrower vectors are zero-extended.
    localparam int MAX_NLEV = 64;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // An empty vector and a vector with only bit 0 both return 0. Level 0
    // is the background level and can never beat PIL, so the two cases
    // need no separate "valid" flag.
    function automatic int prio_enc(input logic [MAX_NLEV-1:0] req);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_NLEV; i++) begin
            if (req[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cga_intr_lvlstack.sv
// Nested-level LIFO: DEPTH entries of LW bits.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   push, din   store din on top (ignored when full)
//   pop         discard top (ignored when empty)
//   top         current top entry, 0 when empty
//   full, empty occupancy flags
// push and pop are never asserted together by the controller.
module cga_intr_lvlstack #(
    parameter int DEPTH = 4,
    parameter int LW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [LW-1:0] din,
    output logic [LW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LW-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign top_idx = AW'(cnt - CW'(1));
    assign wr_idx  = AW'(cnt);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            if (!full) begin
                mem[wr_idx] <= din;
                cnt         <= cnt + CW'(1);
            end
        end else if (pop) begin
            if (!empty) cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/cga_intr_prio_ctrl.sv
// CGA interrupt priority controller.
// Synchronises active-low request lines into a pending register (PID), masks
// it with PIE, and raises a registered IRQ for the highest enabled pending
// level above the current level PIL. IACK enters the level (old PIL pushed on
// a nested-level stack), IRET returns to the previous level.
// Ports:
//   MCLK, RESETN   clock / asynchronous active-low reset
//   IREQ_N         raw active-low requests (asynchronous)
//   FIDBO, LAA,WRN register write data / select / active-low strobe
//   IACK, IRET     CPU acknowledge / return pulses
//   RDATA          register read mux selected by LAA
//   IRQ, INTRQN    interrupt request and its complement
//   VEC            level being requested (valid while IRQ=1)
//   PIL            current level
//   STKERR         sticky stack overflow/underflow
//   dbg_state      controller FSM state
// Handshake: IRQ stays high with VEC tracking the best qualifying level until
// either IACK is seen (level entered, IRQ drops next edge) or the request
// stops qualifying (IRQ withdrawn). IACK while IRQ is low has no effect.
module cga_intr_prio_ctrl
    import cga_intr_pkg::*;
#(
    parameter int              NLEV     = 16,
    parameter int              LW       = 4,
    parameter int              DEPTH    = 4,
    parameter logic [NLEV-1:0] EDGEMASK = '1
) (
    input  logic            MCLK,
    input  logic            RESETN,
    input  logic [NLEV-1:0] IREQ_N,
    input  logic [NLEV-1:0] FIDBO,
    input  logic [1:0]      LAA,
    input  logic            WRN,
    input  logic            IACK,
    input  logic            IRET,
    output logic [NLEV-1:0] RDATA,
    output logic            IRQ,
    output logic            INTRQN,
    output logic [LW-1:0]   VEC,
    output logic [LW-1:0]   PIL,
    output logic            STKERR,
    output state_t          dbg_state
);

    // sync1/sync2 form the synchroniser; sync3 is the previous sync2 value
    // used for falling-edge detection.
    logic [NLEV-1:0] sync1, sync2, sync3;
    logic [NLEV-1:0] pie, pid, pid_n, fall, masked;
    logic [LW-1:0]   pil, pil_n, vec, vec_n, best, stk_top;
    logic            stkerr;
    logic            qual, wr, push, pop, stk_full, stk_empty;
    state_t          state, state_n;

    assign wr     = !WRN;
    assign masked = pid & pie;
    assign best   = LW'(prio_enc(MAX_NLEV'(masked)));
    assign qual   = (best > pil);
    assign fall   = EDGEMASK & sync3 & ~sync2;

    // IACK is only meaningful while a request is outstanding; it beats IRET.
    assign pop = IRET && !push;

    always_comb begin
        state_n = state;
        vec_n   = vec;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (qual) begin
                    state_n = REQ;
                    vec_n   = best;
                end
            end
            REQ: begin
                if (IACK) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else if (!qual) begin
                    state_n = IDLE;
                end else begin
                    vec_n = best;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pending: software set/clear and IACK clear touch edge-mode bits only;
    // a hardware edge is OR-ed in last so it survives a same-cycle clear.
    // Level-mode bits simply follow the synchronised request.
    always_comb begin
        pid_n = pid;
        if (wr && LAA == LAA_PID_SET) pid_n = pid_n | (FIDBO & EDGEMASK);
        if (wr && LAA == LAA_PID_CLR) pid_n = pid_n & ~(FIDBO & EDGEMASK);
        if (push && EDGEMASK[vec])    pid_n[vec] = 1'b0;
        pid_n = pid_n | fall;
        pid_n = (pid_n & EDGEMASK) | (~sync2 & ~EDGEMASK);
    end

    // Stack pop on empty returns 0, which is exactly the background level.
    always_comb begin
        pil_n = pil;
        if (wr && LAA == LAA_PIL) pil_n = FIDBO[LW-1:0];
        if (push)      pil_n = vec;
        else if (pop)  pil_n = stk_top;
    end

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1  <= '1;
            sync2  <= '1;
            sync3  <= '1;
            pie    <= '0;
            pid    <= '0;
            pil    <= '0;
            vec    <= '0;
            stkerr <= 1'b0;
            state  <= IDLE;
        end else begin
            sync1  <= IREQ_N;
            sync2  <= sync1;
            sync3  <= sync2;
            if (wr && LAA == LAA_PIE) pie <= FIDBO;
            pid    <= pid_n;
            pil    <= pil_n;
            vec    <= vec_n;
            state  <= state_n;
            if ((push && stk_full) || (pop && stk_empty)) stkerr <= 1'b1;
        end
    end

    cga_intr_lvlstack #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_stack (
        .clk   (MCLK),
        .rst_n (RESETN),
        .push  (push),
        .pop   (pop),
        .din   (pil),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        RDATA = '0;
        case (LAA)
            LAA_PIE:     RDATA = pie;
            LAA_PID_SET: RDATA = pid;
            LAA_PID_CLR: RDATA = pid & pie;
            default:     RDATA = NLEV'(pil);
        endcase
    end

    // IRQ is the state register itself, so it falls with RESETN asynchronously.
    assign IRQ       = (state == REQ);
    assign INTRQN    = ~IRQ;
    assign VEC       = vec;
    assign PIL       = pil;
    assign STKERR    = stkerr;
    assign dbg_state = state;

endmodule

// File: tb/tb_cga_intr_prio_ctrl.sv
module tb_cga_intr_prio_ctrl;
  import cga_intr_pkg::*;

  localparam int NLEV  = 16;
  localparam int LW    = 4;
  localparam int DEPTH = 4;
  // bits 6 and 7 level-sensitive, all others edge-triggered
  localparam logic [NLEV-1:0] EDGEMASK = 16'hFF3F;

  // ---------------- clock / reset / DUT ----------------
  logic            MCLK = 1'b0;
  logic            RESETN;
  logic [NLEV-1:0] IREQ_N;
  logic [NLEV-1:0] FIDBO;
  logic [1:0]      LAA;
  logic            WRN, IACK, IRET;
  logic [NLEV-1:0] RDATA;
  logic            IRQ, INTRQN, STKERR;
  logic [LW-1:0]   VEC, PIL;
  state_t          dbg_state;

  always #5 MCLK = ~MCLK;

  cga_intr_prio_ctrl #(
    .NLEV(NLEV), .LW(LW), .DEPTH(DEPTH), .EDGEMASK(EDGEMASK)
  ) dut (
    .MCLK(MCLK), .RESETN(RESETN), .IREQ_N(IREQ_N), .FIDBO(FIDBO), .LAA(LAA),
    .WRN(WRN), .IACK(IACK), .IRET(IRET), .RDATA(RDATA), .IRQ(IRQ),
    .INTRQN(INTRQN), .VEC(VEC), .PIL(PIL), .STKERR(STKERR), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [NLEV-1:0] m_pie, m_pid;
  logic [LW-1:0]   m_pil, m_vec;
  logic            m_irq, m_err;
  logic [LW-1:0]   m_stack[$];
  logic [NLEV-1:0] m_hist[3];   // [0]=last sampled IREQ_N, [1]=one before, [2]=two before

  task automatic model_reset();
    m_pie = '0; m_pid = '0; m_pil = '0; m_vec = '0;
    m_irq = 1'b0; m_err = 1'b0;
    m_stack.delete();
    for (int i = 0; i < 3; i++) m_hist[i] = '1;
  endtask

  // One rising edge of the specified behaviour, applied to the current inputs.
  task automatic model_step();
    int              best;
    logic            qual, iack_eff, iret_eff;
    logic [NLEV-1:0] n_pid, n_pie;
    logic [LW-1:0]   n_pil, n_vec;
    logic            n_irq;
    best = 0;
    for (int i = 0; i < NLEV; i++) if (m_pid[i] && m_pie[i]) best = i;
    qual     = (best > int'(m_pil));
    iack_eff = IACK && m_irq;
    iret_eff = IRET && !iack_eff;
    n_pid = m_pid; n_pie = m_pie; n_pil = m_pil; n_vec = m_vec; n_irq = m_irq;
    if (!WRN) begin
      case (LAA)
        2'd0: n_pie = FIDBO;
        2'd1: n_pid = n_pid | (FIDBO & EDGEMASK);
        2'd2: n_pid = n_pid & ~(FIDBO & EDGEMASK);
        default: n_pil = FIDBO[LW-1:0];
      endcase
    end
    if (m_irq) begin
      if (iack_eff) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_pil);
        n_pil = m_vec;
        if (EDGEMASK[m_vec]) n_pid[m_vec] = 1'b0;
        n_irq = 1'b0;
      end else if (!qual) begin
        n_irq = 1'b0;
      end else begin
        n_vec = LW'(best);
      end
    end else if (qual) begin
      n_irq = 1'b1;
      n_vec = LW'(best);
    end
    if (iret_eff) begin
      if (m_stack.size() == 0) begin
        n_pil = '0;
        m_err = 1'b1;
      end else begin
        n_pil = m_stack.pop_back();
      end
    end
    for (int i = 0; i < NLEV; i++) begin
      if (EDGEMASK[i]) begin
        if (!m_hist[1][i] && m_hist[2][i]) n_pid[i] = 1'b1;
      end else begin
        n_pid[i] = !m_hist[1][i];
      end
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = IREQ_N;
    m_pid = n_pid; m_pie = n_pie; m_pil = n_pil; m_vec = n_vec; m_irq = n_irq;
  endtask

  function automatic logic [NLEV-1:0] model_rdata(input logic [1:0] sel);
    case (sel)
      2'd0: return m_pie;
      2'd1: return m_pid;
      2'd2: return m_pid & m_pie;
      default: return NLEV'(m_pil);
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("irq",    32'(IRQ),    32'(m_irq));
    chk("intrqn", 32'(INTRQN), 32'(!m_irq));
    chk("vec",    32'(VEC),    32'(m_vec));
    chk("pil",    32'(PIL),    32'(m_pil));
    chk("stkerr", 32'(STKERR), 32'(m_err));
    chk("rdata",  32'(RDATA),  32'(model_rdata(LAA)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge MCLK);
    model_step();
    #1;
    check_all();
    WRN = 1'b1; IACK = 1'b0; IRET = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [NLEV-1:0] data);
    LAA = sel; FIDBO = data; WRN = 1'b0;
    tick();
    LAA = 2'd1;
  endtask

  // one-cycle low pulse; the edge is sampled on the tick inside
  task automatic pulse(input int lvl);
    IREQ_N[lvl] = 1'b0;
    tick();
    IREQ_N[lvl] = 1'b1;
  endtask

  task automatic do_iack();
    IACK = 1'b1;
    tick();
  endtask

  task automatic do_iret();
    IRET = 1'b1;
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lvls[5];
    lvls = '{5, 10, 11, 12, 13};
    RESETN = 1'b0; IREQ_N = '1; FIDBO = '0; LAA = 2'd1;
    WRN = 1'b1; IACK = 1'b0; IRET = 1'b0;
    model_reset();
    #12;
    chk("rst_irq",    32'(IRQ),    32'd0);
    chk("rst_intrqn", 32'(INTRQN), 32'd1);
    chk("rst_pil",    32'(PIL),    32'd0);
    chk("rst_vec",    32'(VEC),    32'd0);
    chk("rst_stkerr", 32'(STKERR), 32'd0);
    chk("rst_pid",    32'(RDATA),  32'd0);
    #5 RESETN = 1'b1;

    // basic request, latency and acknowledge
    wr_reg(2'd0, 16'h0400);
    IREQ_N[10] = 1'b0;
    tick(); chk("lat_k0", 32'(IRQ), 32'd0);
    tick(); chk("lat_k1", 32'(IRQ), 32'd0);
    tick(); chk("lat_k2", 32'(IRQ), 32'd0);
    IREQ_N[10] = 1'b1;
    tick(); chk("lat_k3", 32'(IRQ), 32'd1);
    chk("lat_vec", 32'(VEC), 32'd10);
    do_iack();
    chk("ack_pil",   32'(PIL),       32'd10);
    chk("ack_irq",   32'(IRQ),       32'd0);
    chk("ack_pid10", 32'(RDATA[10]), 32'd0);

    // nesting
    wr_reg(2'd0, 16'h3C20);
    pulse(12); ticks(3);
    chk("nest_irq12", 32'(IRQ), 32'd1);
    chk("nest_vec12", 32'(VEC), 32'd12);
    do_iack();
    chk("nest_pil12", 32'(PIL), 32'd12);
    pulse(11); ticks(4);
    chk("nest_hold11", 32'(IRQ),       32'd0);
    chk("nest_pend11", 32'(RDATA[11]), 32'd1);
    do_iret();
    chk("nest_ret_pil", 32'(PIL), 32'd10);
    tick();
    chk("nest_irq11", 32'(IRQ), 32'd1);
    chk("nest_vec11", 32'(VEC), 32'd11);
    do_iack();
    chk("nest_pil11", 32'(PIL), 32'd11);
    do_iret(); do_iret();
    chk("nest_back0", 32'(PIL),    32'd0);
    chk("nest_noerr", 32'(STKERR), 32'd0);

    // preemption while requesting
    pulse(5); ticks(3);
    chk("pre_vec5", 32'(VEC), 32'd5);
    pulse(13); ticks(3);
    chk("pre_irq",   32'(IRQ), 32'd1);
    chk("pre_vec13", 32'(VEC), 32'd13);
    do_iack();
    chk("pre_pil13", 32'(PIL),       32'd13);
    chk("pre_pid5",  32'(RDATA[5]),  32'd1);
    chk("pre_pid13", 32'(RDATA[13]), 32'd0);
    do_iret();
    wr_reg(2'd2, 16'h0020);
    ticks(2);
    chk("pre_clr5", 32'(IRQ), 32'd0);

    // stack overflow / underflow
    for (int j = 0; j < 5; j++) begin
      pulse(lvls[j]); ticks(3);
      chk("stk_vec", 32'(VEC), 32'(lvls[j]));
      do_iack();
      chk("stk_pil", 32'(PIL), 32'(lvls[j]));
      if (j == 3) chk("stk_err_full", 32'(STKERR), 32'd0);
    end
    chk("stk_ovf", 32'(STKERR), 32'd1);
    do_iret();
    chk("stk_pop1", 32'(PIL), 32'd11);
    ticks(1);
    do_iret(); do_iret(); do_iret();
    chk("stk_pop4", 32'(PIL), 32'd0);
    do_iret();
    chk("stk_unf_pil", 32'(PIL),    32'd0);
    chk("stk_unf_err", 32'(STKERR), 32'd1);

    // IACK and IRET together: push only
    pulse(10); ticks(3);
    chk("sim_vec", 32'(VEC), 32'd10);
    IACK = 1'b1; IRET = 1'b1;
    tick();
    chk("sim_pil", 32'(PIL), 32'd10);
    do_iret();
    chk("sim_ret", 32'(PIL), 32'd0);

    // clear write colliding with a new edge on the same bit
    IREQ_N[11] = 1'b0; tick();
    IREQ_N[11] = 1'b1; tick();
    LAA = 2'd2; FIDBO = 16'h0800; WRN = 1'b0;
    tick();
    LAA = 2'd1; #1;
    chk("clr_vs_edge", 32'(RDATA[11]), 32'd1);

    // reset in the middle of a request
    ticks(2);
    chk("mid_irq_pre", 32'(IRQ), 32'd1);
    #3 RESETN = 1'b0;
    #1;
    chk("mid_irq",    32'(IRQ),    32'd0);
    chk("mid_intrqn", 32'(INTRQN), 32'd1);
    chk("mid_pil",    32'(PIL),    32'd0);
    chk("mid_pid",    32'(RDATA),  32'd0);
    chk("mid_stkerr", 32'(STKERR), 32'd0);
    model_reset();
    #2 RESETN = 1'b1;
    ticks(2);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NLEV; i++)
        if ($urandom_range(0, 11) == 0) IREQ_N[i] = ~IREQ_N[i];
      LAA   = 2'($urandom_range(0, 3));
      FIDBO = NLEV'($urandom);
      WRN   = ($urandom_range(0, 7) != 0);
      IACK  = ($urandom_range(0, 3) == 0);
      IRET  = ($urandom_range(0, 9) == 0);
      tick();
      LAA = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_rdata", 32'(RDATA), 32'(model_rdata(LAA)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
